// File: rtl/bcd_conv_scheduler_if.sv
// ============================================================================
// Module   : bcd_conv_scheduler_if
// Purpose  : Requester, converter and result signals of the BCD scheduler.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface bcd_conv_scheduler_if;
    logic [3:0]  req;
    logic [63:0] data_in;
    logic [3:0]  ack;
    logic [15:0] conv_data;
    logic [15:0] conv_bcd;
    logic [15:0] bcd_out;
    logic [1:0]  ch_out;
    logic        ovf_out;
    logic        bcd_valid;
    logic        busy;

    modport slave (
        input  req, data_in, conv_bcd,
        output ack, conv_data, bcd_out, ch_out, ovf_out, bcd_valid, busy
    );

    modport master (
        output req, data_in, conv_bcd,
        input  ack, conv_data, bcd_out, ch_out, ovf_out, bcd_valid, busy
    );
endinterface

`default_nettype wire

// File: rtl/bcd_conv_scheduler.sv
// ============================================================================
// Module   : bcd_conv_scheduler
// Purpose  : Round-robin sharing of one free-running binary-to-BCD converter
//            among four requesters, with clamping and channel tagging.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_conv_scheduler #(
    parameter int          N_CH       = 4,
    parameter int          SETTLE_CYC = 80,
    parameter int          CNT_W      = 7,
    parameter logic [15:0] BCD_MAX    = 16'd9999
) (
    input  wire logic           sys_clk,
    input  wire logic           sys_rst_n,
    bcd_conv_scheduler_if.slave bus
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]  last_grant_q, last_grant_d;
    logic [1:0]  grant_q, grant_d;
    logic        ovf_pend_q, ovf_pend_d;
    logic [15:0] conv_data_q, conv_data_d;
    logic [15:0] bcd_q, bcd_d;
    logic [1:0]  ch_q, ch_d;
    logic        ovf_q, ovf_d;
    logic [3:0]  ack_q, ack_d;
    logic        valid_q, valid_d;

    logic        arb_found;
    logic [1:0]  arb_grant;
    logic [1:0]  arb_idx;
    logic [15:0] sel_data;
    logic        sel_ovf;

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        arb_found = 1'b0;
        arb_grant = 2'd0;
        arb_idx   = 2'd0;
        for (int k = 1; k <= N_CH; k++) begin
            arb_idx = last_grant_q + 2'(k);
            if (!arb_found && bus.req[arb_idx]) begin
                arb_found = 1'b1;
                arb_grant = arb_idx;
            end
        end
    end

    assign sel_data = bus.data_in[{arb_grant, 4'b0000} +: 16];
    assign sel_ovf  = (sel_data > BCD_MAX);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        ovf_pend_d   = ovf_pend_q;
        conv_data_d  = conv_data_q;
        bcd_d        = bcd_q;
        ch_d         = ch_q;
        ovf_d        = ovf_q;
        ack_d        = 4'b0000;
        valid_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (arb_found) begin
                    conv_data_d  = sel_ovf ? BCD_MAX : sel_data;
                    ovf_pend_d   = sel_ovf;
                    ack_d        = 4'b0001 << arb_grant;
                    grant_d      = arb_grant;
                    last_grant_d = arb_grant;
                    cnt_d        = '0;
                    state_d      = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // The window spans two full converter periods, so conv_bcd
                // now reflects conv_data regardless of converter phase.
                if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
                    bcd_d   = bus.conv_bcd;
                    ch_d    = grant_q;
                    ovf_d   = ovf_pend_q;
                    valid_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            last_grant_q <= 2'd3;
            grant_q      <= 2'd0;
            ovf_pend_q   <= 1'b0;
            conv_data_q  <= 16'd0;
            bcd_q        <= 16'd0;
            ch_q         <= 2'd0;
            ovf_q        <= 1'b0;
            ack_q        <= 4'b0000;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            ovf_pend_q   <= ovf_pend_d;
            conv_data_q  <= conv_data_d;
            bcd_q        <= bcd_d;
            ch_q         <= ch_d;
            ovf_q        <= ovf_d;
            ack_q        <= ack_d;
            valid_q      <= valid_d;
        end
    end

    assign bus.ack       = ack_q;
    assign bus.conv_data = conv_data_q;
    assign bus.bcd_out   = bcd_q;
    assign bus.ch_out    = ch_q;
    assign bus.ovf_out   = ovf_q;
    assign bus.bcd_valid = valid_q;
    assign bus.busy      = (state_q == ST_WAIT);

endmodule

`default_nettype wire

// File: doc/bcd_conv_scheduler.md
Name: bcd_conv_scheduler

Overview:
Round-robin scheduler that shares one binary-to-BCD converter among 4 requesters, e.g. LCD value fields such as frequency, amplitude, duty and count.
- Each requester raises a level request with a 16-bit binary value.
- The block grants one requester, clamps its value and drives the converter input. It holds that input stable for a settle window, then captures the BCD result and tags it with the channel index.
- The converter is the team's free-running shift-and-add-3 unit. It resamples its input every 36 clocks and updates its output up to 36 clocks later.

Parameters:
- N_CH, 4, number of requesters. Fixed at 4; ch index width is 2.
- SETTLE_CYC, 80, clocks conv_data is held before conv_bcd is sampled. Must be ≥ 2 × 36 + margin.
- CNT_W, 7, width of the settle counter. Must hold SETTLE_CYC-1.
- BCD_MAX, 9999, largest representable value (4 BCD digits).

Ports:
- sys_clk  in  1  system clock
- sys_rst_n  in  1  asynchronous, active-low reset
- req  in  4  per-channel level request
- data_in  in  64  channel i value at [16i+15:16i], unsigned binary
- ack  out  4  one-hot, one-cycle pulse: channel's data has been latched
- conv_data  out  16  binary value to the shared converter
- conv_bcd  in  16  BCD result from the shared converter
- bcd_out  out  16  captured BCD result, 4 digits, [15:12] = thousands
- ch_out  out  2  channel index of bcd_out
- ovf_out  out  1  value was clamped to 9999
- bcd_valid  out  1  one-cycle pulse: bcd_out/ch_out/ovf_out updated
- busy  out  1  high while state = WAIT

Behaviour:
Reset: all of the following take these values.
- ack = 0, conv_data = 0, bcd_out = 0, ch_out = 0, ovf_out = 0, bcd_valid = 0, busy = 0.
- state = IDLE, settle counter = 0, last_grant = 3, so channel 0 has first priority.
- Reset asserted mid-WAIT aborts the conversion. No bcd_valid and no ack are issued for it.

FSM states: IDLE, WAIT.

IDLE:
- With req == 0, stay in IDLE.
- Otherwise grant g = first set bit of req, searching last_grant+1, +2, +3, +4 mod 4.
- Registered at the clock edge:
  - conv_data = min(data_in[g], 9999); ovf_pending = (data_in[g] > 9999).
  - ack[g] = 1, all other ack bits = 0.
  - grant register = g; last_grant = g; counter = 0; state = WAIT.

WAIT:
- busy = 1. Counter increments each cycle.
- When counter == SETTLE_CYC-1, register:
  - bcd_out = conv_bcd; ch_out = g; ovf_out = ovf_pending; bcd_valid = 1; state = IDLE.
- req is ignored during WAIT. Requests are not queued; level requests are simply re-evaluated in IDLE.

Timing, with the IDLE grant decision in cycle 0:
- ack visible in cycle 1.
- bcd_valid visible in cycle SETTLE_CYC+1.
- A new grant can be decided in that same cycle SETTLE_CYC+1, giving its ack in cycle SETTLE_CYC+2.
- Throughput: one conversion per SETTLE_CYC+1 cycles.

Output holding and pulses:
- conv_data holds its value from grant until the next grant, including through IDLE.
- bcd_out, ch_out and ovf_out hold until the next capture.
- ack and bcd_valid are single-cycle pulses and are never asserted in the same cycle for the same conversion.

Requester protocol:
- A requester deasserts req in response to ack.
- If req stays high after ack, that is a new request. It is re-arbitrated, so other pending channels are served first.
- data_in[i] only needs to be stable in the cycle its grant is decided.
- Simultaneous requests: strict rotation from last_grant. No channel waits more than 3 conversions.
- Counter wrap-around cannot occur: the counter is cleared on every grant.

Test Plan:
- Single request: ch0 req with 1234. Expected: ack = 0001 in cycle 1, busy = 1 for cycles 1..80, then in cycle 81 bcd_valid = 1, bcd_out = 0x1234, ch_out = 0, ovf_out = 0.
- All four requesters: all req held with 1, 22, 333, 4444, each dropping req on its ack. Expected: results 0x0001/ch0, 0x0022/ch1, 0x0333/ch2, 0x4444/ch3, with bcd_valid 81 cycles apart.
- Clamp and edge values: ch2 with 65535. Expected: conv_data = 9999, bcd_out = 0x9999, ovf_out = 1. Then ch2 with 9999 gives 0x9999, ovf_out = 0. Then ch2 with 0 gives 0x0000.
- Fairness: ch0 req held permanently at 5, ch2 req raised at cycle 10 with 77. Expected: grant order ch0, ch2, ch0, with ch2's result 0x0077.
- Reset mid-WAIT: ch1 with 4321, sys_rst_n pulsed low at cycle 40. Expected: no bcd_valid, all outputs 0. After release, req = 1111 (all channels) grants ch0 first.
- Back-to-back: ch3 req held with a value changing 100 → 200 between grants. Expected: results 0x0100 then 0x0200, ack pulses exactly 81 cycles apart.
